// File: rtl/motor_cmd_pkg.sv
// Purpose: shared types and constants for the motor command sequencer.
// Contents: sequencer state enum, driver control-word layout, width/period constants.
package motor_cmd_pkg;

    localparam int unsigned WIDTH_W        = 19;
    localparam int unsigned START_BIT      = 31;
    localparam int unsigned CTRL_W         = START_BIT + 1;
    localparam int unsigned PERIOD_DEFAULT = 660000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Driver control word: [31]=start, [30:19]=reserved zero, [18:0]=high time
    typedef struct packed {
        logic                         start;
        logic [START_BIT-WIDTH_W-1:0] rsvd;
        logic [WIDTH_W-1:0]           width;
    } ctrl_t;

    function automatic ctrl_t make_ctrl(input logic start, input logic [WIDTH_W-1:0] width);
        ctrl_t c;
        c.start = start;
        c.rsvd  = '0;
        c.width = width;
        return c;
    endfunction

endpackage

// File: rtl/motor_cmd_queue_if.sv
// Purpose: command-write, status and driver-handshake bundle of motor_cmd_queue.
// master: command writer / driver side (drives strobes, width and ack).
// slave : the sequencer (drives control word, queue status and error flags).
interface motor_cmd_queue_if #(
    parameter int unsigned DEPTH = 8
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                                wr_en;
    logic [motor_cmd_pkg::WIDTH_W-1:0]   wr_width;
    logic                                flush;
    logic                                err_clr;
    logic                                motor_ack;
    logic [motor_cmd_pkg::CTRL_W-1:0]    motor_control;
    logic                                busy;
    logic [CNT_W-1:0]                    q_count;
    logic                                q_full;
    logic                                q_empty;
    logic                                err_ovf;
    logic                                err_range;
    logic                                err_timeout;

    modport master (
        output wr_en, wr_width, flush, err_clr, motor_ack,
        input  motor_control, busy, q_count, q_full, q_empty,
               err_ovf, err_range, err_timeout
    );

    modport slave (
        input  wr_en, wr_width, flush, err_clr, motor_ack,
        output motor_control, busy, q_count, q_full, q_empty,
               err_ovf, err_range, err_timeout
    );
endinterface

// File: rtl/motor_cmd_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO with flush and first-word-fall-through head.
// Ports: clk/reset; push_i/pop_i/flush_i strobes, data_i write data;
//        head_o oldest entry, count_o/full_o/empty_o occupancy status.
module motor_cmd_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 19,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q;
    logic              do_push_c, do_pop_c;

    // A push into a full FIFO is only taken when a pop frees a slot that cycle
    assign do_push_c = push_i & ~flush_i & (~full_q | pop_i);
    assign do_pop_c  = pop_i & ~empty_q;

    // Pointer/count next state; flush drops everything still stored
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/motor_cmd_queue.sv
// Purpose: buffers pulse-width commands and issues them one at a time to the
//          gpio4 PWM driver using its start-bit / ack handshake.
// Ports: clk, reset (async, active-high); bus (slave modport): write strobe and
//        width, flush, err_clr, motor_ack in; motor_control, busy, queue status
//        and sticky error flags out.
module motor_cmd_queue
    import motor_cmd_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PERIOD      = PERIOD_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    motor_cmd_queue_if.slave  bus
);
    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [31:0] PERIOD_L = 32'(PERIOD);

    state_e             state_q;
    ctrl_t              ctrl_q;
    logic               busy_q;
    logic [TMR_W-1:0]   timer_q;
    logic               err_ovf_q, err_range_q, err_timeout_q;

    logic [WIDTH_W-1:0] head_c;
    logic [CNT_W-1:0]   fifo_count_c;
    logic               fifo_full_c, fifo_empty_c;
    logic               wr_legal_c, push_c, pop_c, timeout_c;
    logic               range_err_c, ovf_err_c;

    // Write qualification: flush suppresses both the write and its error reporting
    assign wr_legal_c  = 32'(bus.wr_width) < PERIOD_L;
    assign pop_c       = (state_q == IDLE) & ~fifo_empty_c & ~bus.motor_ack;
    assign push_c      = bus.wr_en & ~bus.flush & wr_legal_c & (~fifo_full_c | pop_c);
    assign range_err_c = bus.wr_en & ~bus.flush & ~wr_legal_c;
    assign ovf_err_c   = bus.wr_en & ~bus.flush & wr_legal_c & fifo_full_c & ~pop_c;
    assign timeout_c   = (state_q == START) & ~bus.motor_ack &
                         (timer_q == TMR_W'(ACK_TIMEOUT - 1));

    motor_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (WIDTH_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (bus.flush),
        .data_i  (bus.wr_width),
        .head_o  (head_c),
        .count_o (fifo_count_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c)
    );

    // Issue sequencer; ctrl_q.width doubles as the active command register.
    // Leaving RUN only on ack low means the driver always sees start low
    // for at least one cycle before the next command is popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        ctrl_q  <= make_ctrl(1'b1, head_c);
                        state_q <= START;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                START: begin
                    if (bus.motor_ack) begin
                        ctrl_q.start <= 1'b0;
                        state_q      <= RUN;
                    end else if (timeout_c) begin
                        ctrl_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.motor_ack) begin
                        ctrl_q  <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    ctrl_q  <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf_q     <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (ovf_err_c)        err_ovf_q     <= 1'b1;
            else if (bus.err_clr) err_ovf_q     <= 1'b0;
            if (range_err_c)      err_range_q   <= 1'b1;
            else if (bus.err_clr) err_range_q   <= 1'b0;
            if (timeout_c)        err_timeout_q <= 1'b1;
            else if (bus.err_clr) err_timeout_q <= 1'b0;
        end
    end

    assign bus.motor_control = ctrl_q;
    assign bus.busy          = busy_q;
    assign bus.q_count       = fifo_count_c;
    assign bus.q_full        = fifo_full_c;
    assign bus.q_empty       = fifo_empty_c;
    assign bus.err_ovf       = err_ovf_q;
    assign bus.err_range     = err_range_q;
    assign bus.err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_motor_cmd_queue.sv
// Bench for motor_cmd_queue: directed scenarios, a table of write vectors and a
// randomized run, all compared every cycle against a queue-based reference model.
// PERIOD is lowered to 500000 so out-of-range widths fit on the 19-bit write port.
module tb_motor_cmd_queue;
    import motor_cmd_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PERIOD = 500000;
    localparam int unsigned TMO    = 1024;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    motor_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    motor_cmd_queue #(
        .DEPTH       (DEPTH),
        .PERIOD      (PERIOD),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending commands as a queue, driver engagement phase
    logic [WIDTH_W-1:0] m_q[$];
    int                 m_ph;      // 0 free, 1 waiting for ack, 2 burst running
    int                 m_wait;    // cycles spent waiting for ack
    logic [WIDTH_W-1:0] m_w;
    bit                 m_ovf, m_rng, m_tmo;

    // Driver model and observation state
    int  ack_mode;                 // 0 driver model, 1 forced high, 2 never acks
    int  drv_st, drv_cnt, drv_len;
    bit  drv_ack;
    bit  prev_start;
    int  run, last_run;
    logic [WIDTH_W-1:0] issued[$];

    typedef struct {
        bit          wr;
        int unsigned w;
        bit          fl;
        bit          clr;
        int unsigned exp_cnt;
        bit          exp_rng;
        bit          exp_ovf;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ph = 0; m_wait = 0; m_w = '0;
        m_ovf = 0; m_rng = 0; m_tmo = 0;
    endtask

    // One clock of the reference behaviour, from the inputs seen at that edge
    task automatic model_step(input bit wr, input int unsigned w, input bit fl,
                              input bit clr, input bit ack);
        bit pop, full, legal, acc, er, eo, et;
        pop   = (m_ph == 0) && (m_q.size() > 0) && !ack;
        full  = (m_q.size() == DEPTH);
        legal = (w < PERIOD);
        acc   = wr && !fl && legal && (!full || pop);
        er    = wr && !fl && !legal;
        eo    = wr && !fl && legal && full && !pop;
        et    = 0;
        if (m_ph == 0) begin
            if (pop) begin m_w = m_q.pop_front(); m_ph = 1; m_wait = 0; end
        end else if (m_ph == 1) begin
            if (ack) m_ph = 2;
            else if (m_wait == TMO - 1) begin m_ph = 0; et = 1; end
            else m_wait++;
        end else begin
            if (!ack) m_ph = 0;
        end
        if (fl) m_q.delete();
        if (acc) m_q.push_back(WIDTH_W'(w));
        m_rng = er ? 1'b1 : (clr ? 1'b0 : m_rng);
        m_ovf = eo ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_tmo = et ? 1'b1 : (clr ? 1'b0 : m_tmo);
    endtask

    function automatic logic [9:0] dut_status();
        return {bus.busy, bus.q_full, bus.q_empty, bus.err_ovf, bus.err_range,
                bus.err_timeout, bus.q_count};
    endfunction

    task automatic compare_model();
        logic [31:0] exp_ctrl;
        logic [9:0]  exp_st;
        exp_ctrl = (m_ph == 0) ? 32'h0 : {(m_ph == 1), 12'b0, m_w};
        exp_st   = {(m_ph != 0), (m_q.size() == DEPTH), (m_q.size() == 0),
                    m_ovf, m_rng, m_tmo, 4'(m_q.size())};
        check("model_ctrl", 64'(bus.motor_control), 64'(exp_ctrl));
        check("model_status", 64'(dut_status()), 64'(exp_st));
    endtask

    // Driver: ack rises two cycles after start appears, held drv_len cycles
    task automatic drv_update();
        case (drv_st)
            0: begin
                drv_ack = 0;
                if (bus.motor_control[START_BIT]) drv_st = 1;
            end
            1: begin drv_st = 2; drv_cnt = drv_len; drv_ack = 1; end
            default: begin
                if (drv_cnt > 1) begin drv_cnt--; drv_ack = 1; end
                else begin drv_st = 0; drv_ack = 0; end
            end
        endcase
    endtask

    task automatic step(input bit wr, input int unsigned w, input bit fl, input bit clr);
        bit a;
        @(negedge clk);
        a = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'b0 : drv_ack;
        bus.wr_en     = wr;
        bus.wr_width  = WIDTH_W'(w);
        bus.flush     = fl;
        bus.err_clr   = clr;
        bus.motor_ack = a;
        @(posedge clk);
        #1;
        model_step(wr, w, fl, clr, a);
        compare_model();
        if (bus.motor_control[START_BIT] && !prev_start)
            issued.push_back(bus.motor_control[WIDTH_W-1:0]);
        prev_start = bus.motor_control[START_BIT];
        if (bus.motor_control[START_BIT]) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        drv_update();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.wr_en = 0; bus.wr_width = '0; bus.flush = 0; bus.err_clr = 0; bus.motor_ack = 0;
        model_reset();
        drv_st = 0; drv_ack = 0; drv_cnt = 0; prev_start = 0;
        run = 0; last_run = 0; issued.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_width = '0; bus.flush = 0; bus.err_clr = 0; bus.motor_ack = 0;
        ack_mode = 0; drv_len = 5;

        // Reset state
        do_reset();
        #1;
        check("reset_ctrl", 64'(bus.motor_control), 64'h0);
        check("reset_status", 64'(dut_status()), 64'(10'b0010000000));

        // Two commands issued in order through the driver handshake
        ack_mode = 0; drv_len = 5;
        step(1, 33000, 0, 0);
        step(1, 49500, 0, 0);
        for (int k = 0; k < 100 && !(issued.size() == 2 && !bus.busy); k++) step(0, 0, 0, 0);
        check("t1_issued_n", 64'(issued.size()), 64'd2);
        check("t1_first", 64'(issued.size() > 0 ? issued[0] : '1), 64'd33000);
        check("t1_second", 64'(issued.size() > 1 ? issued[1] : '1), 64'd49500);
        check("t1_empty", 64'(bus.q_empty), 64'd1);

        // Overflow while blocked by a foreign ack, then pop+write at full
        do_reset();
        ack_mode = 1;
        for (int i = 0; i < 9; i++) step(1, 1000 + i, 0, 0);
        check("t2_count", 64'(bus.q_count), 64'd8);
        check("t2_full", 64'(bus.q_full), 64'd1);
        check("t2_ovf", 64'(bus.err_ovf), 64'd1);
        check("t2_idle", 64'(bus.busy), 64'd0);
        step(0, 0, 0, 1);
        check("t2_ovf_clr", 64'(bus.err_ovf), 64'd0);
        ack_mode = 0; drv_len = 4;
        step(1, 2000, 0, 0);
        check("t2_popwr_count", 64'(bus.q_count), 64'd8);
        check("t2_popwr_ovf", 64'(bus.err_ovf), 64'd0);
        for (int k = 0; k < 400 && !(issued.size() == 9 && !bus.busy); k++) step(0, 0, 0, 0);
        check("t2_issued_n", 64'(issued.size()), 64'd9);
        for (int i = 0; i < 9; i++)
            check($sformatf("t2_issued%0d", i), 64'(issued.size() > i ? issued[i] : '1),
                  (i < 8) ? 64'(1000 + i) : 64'd2000);

        // Table of write vectors with the driver held busy (no pops)
        vecs[0] = '{1'b1, 500000, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 524287, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 0,      1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 499999, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 500000, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 0,      1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1234,   1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 524287, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 7,      1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 0,      1'b1, 1'b0, 0, 1'b0, 1'b0};
        do_reset();
        ack_mode = 1;
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].wr, vecs[i].w, vecs[i].fl, vecs[i].clr);
            check($sformatf("vec%0d_cnt", i), 64'(bus.q_count), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_rng", i), 64'(bus.err_range), 64'(vecs[i].exp_rng));
            check($sformatf("vec%0d_ovf", i), 64'(bus.err_ovf), 64'(vecs[i].exp_ovf));
        end

        // Ack timeout: start high exactly TMO cycles, next command then issued
        do_reset();
        ack_mode = 2;
        step(1, 20000, 0, 0);
        step(1, 30000, 0, 0);
        for (int k = 0; k < 3000 && last_run == 0; k++) step(0, 0, 0, 0);
        check("t4_start_len", 64'(last_run), 64'(TMO));
        check("t4_err_timeout", 64'(bus.err_timeout), 64'd1);
        for (int k = 0; k < 10 && issued.size() < 2; k++) step(0, 0, 0, 0);
        check("t4_next", 64'(issued.size() > 1 ? issued[1] : '1), 64'd30000);

        // Flush during a running burst
        do_reset();
        ack_mode = 0; drv_len = 30;
        step(1, 11000, 0, 0);
        step(1, 12000, 0, 0);
        step(1, 13000, 0, 0);
        step(1, 14000, 0, 0);
        for (int k = 0; k < 20 && !(bus.busy && !bus.motor_control[START_BIT]); k++)
            step(0, 0, 0, 0);
        check("t5_queued", 64'(bus.q_count), 64'd3);
        step(0, 0, 1, 0);
        check("t5_flushed", 64'(bus.q_count), 64'd0);
        check("t5_active", 64'(bus.motor_control), 64'd11000);
        for (int k = 0; k < 100 && bus.busy; k++) step(0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
        check("t5_issued_n", 64'(issued.size()), 64'd1);
        check("t5_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset while the start bit is high
        do_reset();
        ack_mode = 2;
        step(1, 524287, 0, 0);
        step(1, 100, 0, 0);
        step(1, 200, 0, 0);
        step(1, 300, 0, 0);
        for (int k = 0; k < 10 && !bus.motor_control[START_BIT]; k++) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t6_pre_start", 64'(bus.motor_control[START_BIT]), 64'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_ctrl", 64'(bus.motor_control), 64'h0);
        check("t6_status", 64'(dut_status()), 64'(10'b0010000000));
        do_reset();

        // Randomized traffic against the reference model
        ack_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          wr, fl, clr;
            int unsigned w;
            wr  = ($urandom_range(0, 99) < 40);
            w   = ($urandom_range(0, 9) == 0) ? $urandom_range(PERIOD, 524287)
                                               : $urandom_range(0, PERIOD - 1);
            fl  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 99) < 5);
            drv_len  = $urandom_range(1, 12);
            ack_mode = (drv_st == 0 && !bus.motor_control[START_BIT] &&
                        $urandom_range(0, 99) < 3) ? 1 : 0;
            step(wr, w, fl, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
